// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback port arbiter.
//   arb_state_t : IDLE (no aux entries), SHARE (aux entries waiting),
//                 DRAIN (pipeline frozen while the aux FIFO empties)
//   aux_entry_t : one buffered aux result at the default widths
package wb_arb_pkg;

  localparam int unsigned ZERO_REG       = 0;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_MAX_WAIT   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHARE,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0]     data;
  } aux_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Synchronous FIFO buffering aux results until they win the write port.
//   clk, rst          : clock, asynchronous active-high reset (empties FIFO)
//   i_push / i_data   : write an entry at the tail (ignored when full)
//   i_pop             : drop the head entry (ignored when empty)
//   o_head            : entry at the head, valid while !o_empty
//   o_full, o_empty   : occupancy flags
//   o_count           : number of buffered entries
module wb_aux_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_FIFO_DEPTH,
  parameter type         entry_t = aux_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  entry_t                     i_data,
  input  logic                       i_pop,
  output entry_t                     o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage and an
// out-of-band aux unit. Aux results are buffered; the pipeline wins by
// default, and the pipeline is frozen to drain the buffer when it fills or
// when its head has waited MAX_WAIT cycles.
//   clk, rst                           : clock, async active-high reset
//   pipe_wr_en/pipe_rd/pipe_result     : writeback request
//   aux_valid/aux_ready/aux_rd/aux_data: aux result handshake
//   rf_we/rf_waddr/rf_wdata            : register-file write port
//   pipe_stall                         : pipeline freeze during drain
//   pending_mask                       : destinations buffered in the FIFO
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wr_en,
  input  logic [REG_ADDR_W-1:0]    pipe_rd,
  input  logic [DATA_W-1:0]        pipe_result,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [REG_ADDR_W-1:0]    aux_rd,
  input  logic [DATA_W-1:0]        aux_data,
  output logic                     rf_we,
  output logic [REG_ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     pipe_stall,
  output logic [2**REG_ADDR_W-1:0] pending_mask
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned NREG   = 2**REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } entry_t;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_draining;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_draining   = (r_state == DRAIN);
  assign aux_ready    = !w_full && !w_draining;
  assign w_push       = aux_valid && aux_ready;
  assign w_push_entry = '{rd: aux_rd, data: aux_data};

  wb_aux_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Grant: pipe first unless draining; a destination of x0 still consumes
  // the request but never enables the write.
  always_comb begin
    w_pop    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = pipe_rd;
    rf_wdata = pipe_result;
    if (!w_draining && pipe_wr_en) begin
      rf_we = (pipe_rd != REG_ADDR_W'(ZERO_REG));
    end else if (!w_empty) begin
      w_pop    = 1'b1;
      rf_waddr = w_head.rd;
      rf_wdata = w_head.data;
      rf_we    = (w_head.rd != REG_ADDR_W'(ZERO_REG));
    end
  end

  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_wait_nxt = r_wait;
    if (w_pop || w_empty) begin
      w_wait_nxt = '0;
    end else if (r_wait != WAIT_W'(MAX_WAIT)) begin
      w_wait_nxt = r_wait + WAIT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = SHARE;
      end
      SHARE: begin
        if (w_count_nxt == '0) begin
          w_state_nxt = IDLE;
        end else if (w_count_nxt == CNT_W'(FIFO_DEPTH) ||
                     w_wait_nxt == WAIT_W'(MAX_WAIT)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_count_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Clear before set so a push and a pop touching different bits both land.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.rd] = 1'b0;
    if (w_push && aux_rd != REG_ADDR_W'(ZERO_REG)) w_pending_nxt[aux_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign pipe_stall   = w_draining;
  assign pending_mask = r_pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wr_en;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_result;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_rd;
  logic [DW-1:0] aux_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          pipe_stall;
  logic [31:0]   pending_mask;

  wb_port_arbiter #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_rd      (pipe_rd),
    .pipe_result  (pipe_result),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_rd       (aux_rd),
    .aux_data     (aux_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pipe_stall   (pipe_stall),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model: the buffer as a queue, a drain flag, a wait counter.
  ent_t q[$];
  bit   m_drain;
  int   m_wait;
  bit   e_pop;
  bit   e_push;
  bit   e_ready;
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic [31:0] emask;
    emask = '0;
    foreach (q[i]) if (q[i].rd != 0) emask[q[i].rd] = 1'b1;
    e_ready = (q.size() < DEPTH) && !m_drain;
    chk("aux_ready", aux_ready, e_ready);
    chk("pipe_stall", pipe_stall, m_drain);
    chk("pending_mask", pending_mask, emask);
    e_pop = 1'b0;
    if (!m_drain && pipe_wr_en) begin
      chk("rf_we(pipe)", rf_we, pipe_rd != 0);
      if (pipe_rd != 0) begin
        chk("rf_waddr(pipe)", rf_waddr, pipe_rd);
        chk("rf_wdata(pipe)", rf_wdata, pipe_result);
      end
    end else if (q.size() > 0) begin
      e_pop = 1'b1;
      chk("rf_we(aux)", rf_we, q[0].rd != 0);
      if (q[0].rd != 0) begin
        chk("rf_waddr(aux)", rf_waddr, q[0].rd);
        chk("rf_wdata(aux)", rf_wdata, q[0].data);
      end
    end else begin
      chk("rf_we(none)", rf_we, 1'b0);
    end
    e_push = aux_valid && e_ready;
  endtask

  task automatic model_update();
    bit   was_empty;
    ent_t e;
    was_empty = (q.size() == 0);
    if (e_pop) void'(q.pop_front());
    if (e_push) begin
      e.rd   = aux_rd;
      e.data = aux_data;
      q.push_back(e);
    end
    if (e_pop || was_empty) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    if (m_drain) begin
      if (q.size() == 0) m_drain = 1'b0;
    end else if (q.size() == DEPTH || (q.size() != 0 && m_wait == MAXW)) begin
      m_drain = 1'b1;
    end
  endtask

  task automatic drive(input bit pwe, input logic [AW-1:0] prd, input logic [DW-1:0] pres,
                       input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
    @(negedge clk);
    pipe_wr_en  = pwe;
    pipe_rd     = prd;
    pipe_result = pres;
    aux_valid   = av;
    aux_rd      = ard;
    aux_data    = ad;
    #1;
    model_compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  int            pct_pipe [3] = '{70, 95, 40};
  int            pct_aux  [3] = '{45, 15, 80};
  bit            cur_pwe;
  logic [AW-1:0] cur_prd;
  logic [DW-1:0] cur_pres;
  bit            offer;
  logic [AW-1:0] cur_ard;
  logic [DW-1:0] cur_ad;
  bit            dup;

  initial begin
    n_cmp = 0; n_bad = 0;
    m_drain = 1'b0; m_wait = 0;
    rst = 1'b1;
    pipe_wr_en = 1'b0; pipe_rd = '0; pipe_result = '0;
    aux_valid = 1'b0; aux_rd = '0; aux_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_aux_ready", aux_ready, 1'b1);
    chk("reset_stall", pipe_stall, 1'b0);
    chk("reset_mask", pending_mask, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single aux push, written the next cycle
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hAAAA_0001);
    chk("t1_ready", aux_ready, 1'b1);
    chk("t1_no_write_yet", rf_we, 1'b0);
    adv();
    idle();
    chk("t1_we", rf_we, 1'b1);
    chk("t1_waddr", rf_waddr, 5'd5);
    chk("t1_wdata", rf_wdata, 32'hAAAA_0001);
    chk("t1_mask5_set", pending_mask[5], 1'b1);
    adv();
    idle();
    chk("t1_mask5_clr", pending_mask[5], 1'b0);
    chk("t1_we_after", rf_we, 1'b0);
    adv();

    // pipe and aux in the same cycle: pipe wins, aux waits for a free cycle
    drive(1'b1, 5'd3, 32'h10, 1'b1, 5'd7, 32'h7777_0007);
    chk("t2_pipe_waddr", rf_waddr, 5'd3);
    chk("t2_pipe_wdata", rf_wdata, 32'h10);
    adv();
    drive(1'b1, 5'd4, 32'h20, 1'b0, '0, '0);
    chk("t2_pipe2_waddr", rf_waddr, 5'd4);
    adv();
    idle();
    chk("t2_aux_we", rf_we, 1'b1);
    chk("t2_aux_waddr", rf_waddr, 5'd7);
    adv();

    // fill to full under a busy pipe, then a four-cycle drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd10, 32'hBEEF, 1'b1, AW'(i + 1), DW'(32'h100 + i));
      chk("t3_fill_ready", aux_ready, 1'b1);
      chk("t3_fill_waddr", rf_waddr, 5'd10);
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd10, 32'hBEEF, 1'b0, '0, '0);
      chk("t3_drain_stall", pipe_stall, 1'b1);
      chk("t3_drain_ready", aux_ready, 1'b0);
      chk("t3_drain_waddr", rf_waddr, AW'(i + 1));
      chk("t3_drain_wdata", rf_wdata, DW'(32'h100 + i));
      adv();
    end
    drive(1'b1, 5'd10, 32'hBEEF, 1'b0, '0, '0);
    chk("t3_release_stall", pipe_stall, 1'b0);
    chk("t3_held_waddr", rf_waddr, 5'd10);
    chk("t3_held_wdata", rf_wdata, 32'hBEEF);
    adv();

    // starvation of a single entry
    drive(1'b1, 5'd11, 32'hC0DE, 1'b1, 5'd9, 32'h9999);
    adv();
    for (int k = 1; k <= MAXW; k++) begin
      drive(1'b1, 5'd11, 32'hC0DE, 1'b0, '0, '0);
      chk("t4_wait_stall", pipe_stall, 1'b0);
      chk("t4_wait_waddr", rf_waddr, 5'd11);
      adv();
    end
    drive(1'b1, 5'd11, 32'hC0DE, 1'b0, '0, '0);
    chk("t4_drain_stall", pipe_stall, 1'b1);
    chk("t4_drain_waddr", rf_waddr, 5'd9);
    chk("t4_drain_wdata", rf_wdata, 32'h9999);
    adv();
    drive(1'b1, 5'd11, 32'hC0DE, 1'b0, '0, '0);
    chk("t4_after_stall", pipe_stall, 1'b0);
    chk("t4_after_waddr", rf_waddr, 5'd11);
    adv();

    // x0 destinations
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    chk("t5_pipe_x0_we", rf_we, 1'b0);
    adv();
    idle();
    chk("t5_aux_x0_we", rf_we, 1'b0);
    chk("t5_mask", pending_mask, 32'h0);
    adv();
    drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h6666);
    chk("t5_empty_we", rf_we, 1'b0);
    adv();
    idle();
    chk("t5_next_we", rf_we, 1'b1);
    chk("t5_next_waddr", rf_waddr, 5'd6);
    adv();

    // reset during drain with three entries left
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd12, 32'h1212, 1'b1, AW'(i + 17), DW'(32'hD00 + i));
      adv();
    end
    drive(1'b1, 5'd12, 32'h1212, 1'b0, '0, '0);
    chk("t6_in_drain", pipe_stall, 1'b1);
    adv();
    #2;
    pipe_wr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", pipe_stall, 1'b0);
    chk("t6_rst_mask", pending_mask, 32'h0);
    chk("t6_rst_we", rf_we, 1'b0);
    chk("t6_rst_ready", aux_ready, 1'b1);
    q.delete();
    m_drain = 1'b0;
    m_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_post_we", rf_we, 1'b0);
      adv();
    end

    // randomized traffic in three load mixes
    offer = 1'b0;
    cur_pwe = 1'b0; cur_prd = '0; cur_pres = '0;
    cur_ard = '0; cur_ad = '0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        if (!m_drain) begin
          cur_pwe  = ($urandom_range(0, 99) < pct_pipe[ph]);
          cur_prd  = AW'($urandom);
          cur_pres = $urandom;
        end
        if (!offer && $urandom_range(0, 99) < pct_aux[ph]) begin
          offer = 1'b1;
          cur_ad = $urandom;
          for (int t = 0; t < 64; t++) begin
            cur_ard = AW'($urandom);
            dup = 1'b0;
            foreach (q[j]) if (q[j].rd == cur_ard && cur_ard != 0) dup = 1'b1;
            if (!dup) break;
          end
        end
        drive(cur_pwe, cur_prd, cur_pres, offer, cur_ard, cur_ad);
        if (e_push) offer = 1'b0;
        adv();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage (wb_result) and an out-of-band multi-cycle unit (mul/div, long-latency load).
- Buffers aux results in a small FIFO and grants the port to the pipeline by default.
- Forces a pipeline freeze to drain the FIFO when it is full or when an aux entry has starved.
- Sits between stage_writeback, the aux unit and the register file; exports a pending-destination mask to the hazard unit.

Parameters:
- DATA_W, 32, register data width.
- REG_ADDR_W, 5, register index width.
- FIFO_DEPTH, 4, aux result buffer entries (power of two, ≥2).
- MAX_WAIT, 8, consecutive ungranted cycles with a non-empty FIFO before a forced drain.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pipe_wr_en  in  1  writeback stage requests a register write this cycle.
- pipe_rd  in  REG_ADDR_W  writeback destination.
- pipe_result  in  DATA_W  wb_result from the writeback stage.
- aux_valid  in  1  aux unit offers a result.
- aux_ready  out  1  arbiter accepts the aux result this cycle.
- aux_rd  in  REG_ADDR_W  aux destination.
- aux_data  in  DATA_W  aux result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- pipe_stall  out  1  freeze pipeline; writeback holds pipe_wr_en/pipe_rd/pipe_result stable.
- pending_mask  out  2**REG_ADDR_W  bit r set while an aux write to r sits in the FIFO.

Behaviour:
- Reset (async): FIFO empty, wait_cnt=0, state IDLE, pending_mask=0, pipe_stall=0.
  - rf_we=0 and aux_ready=1 while the FIFO is empty and pipe_wr_en=0.
  - Reset mid-operation discards buffered entries.
- Push: aux_valid && aux_ready writes {aux_rd, aux_data} at the tail.
  - aux_ready = !full && state!=DRAIN.
  - A pop in the same cycle does not raise aux_ready when full.
- Grant is combinational:
  - IDLE/SHARE: pipe_wr_en=1 → pipe wins, rf_* from pipe_*.
  - Else FIFO non-empty → pop head, rf_* from head.
  - DRAIN: FIFO head always wins; pipe_wr_en is ignored and the request is held by the stall.
- Latency:
  - Pipe write reaches the register file in the same cycle.
  - Aux entry pushed in cycle N is writable at the earliest in cycle N+1.
  - Aux entries retire in FIFO order.
- x0: a grant with destination 0 drives rf_we=0 but still consumes the request/entry.
- pending_mask:
  - Set bit aux_rd on push (rd≠0); clear bit head rd on pop.
  - Simultaneous set/clear of different bits both apply.
  - The aux unit never has two outstanding writes to the same rd.
  - The hazard unit stalls issue on a set bit, so no WAW between pipe and FIFO exists.
- wait_cnt:
  - Cleared on pop or when empty.
  - Otherwise incremented if FIFO non-empty and not popped.
  - Saturates at MAX_WAIT.
- FSM (registered):
  - IDLE → SHARE when the FIFO becomes non-empty.
  - SHARE → IDLE when the FIFO becomes empty.
  - SHARE → DRAIN when next count==FIFO_DEPTH or next wait_cnt==MAX_WAIT.
  - DRAIN → IDLE when the last entry pops.
  - pipe_stall=1 exactly while state==DRAIN.
  - DRAIN terminates in ≤FIFO_DEPTH cycles because pushes are blocked.
- Full and starvation thresholds reached in the same cycle → single DRAIN entry.

Decomposition:
- Shared package wb_arb_pkg:
  - arb_state_t enum {IDLE, SHARE, DRAIN}.
  - aux_entry_t struct {rd, data}.
  - Constants ZERO_REG=0, default depth and MAX_WAIT.
- Sub-module wb_aux_fifo: synchronous FIFO with push/pop, full, empty, count and head.
- wb_port_arbiter holds the grant mux, wait counter, FSM and pending_mask.

Test Plan:
- Reset then aux push rd=5 data=0xAAAA_0001 with pipe_wr_en=0:
  - aux_ready=1.
  - Next cycle rf_we=1, waddr=5, wdata=0xAAAA_0001.
  - pending_mask[5] is 1 for exactly one cycle.
- pipe_wr_en=1 rd=3 data=0x10 in the same cycle as an aux push rd=7:
  - Pipe writes rd 3 that cycle.
  - Aux rd 7 is written the first cycle pipe_wr_en=0.
- Aux pushes rd 1-4 back-to-back while pipe_wr_en=1 continuously:
  - aux_ready=0 after the 4th push.
  - pipe_stall=1 next cycle for 4 cycles.
  - rf writes rd 1,2,3,4 in order.
  - The held pipe write completes in the cycle after pipe_stall drops.
- One aux entry rd=9 with pipe_wr_en=1 for 8 cycles:
  - DRAIN entered after the 8th ungranted cycle.
  - pipe_stall=1 for 1 cycle; rd 9 is written; pipe_stall=0.
- aux_rd=0 and pipe_rd=0 requests:
  - rf_we stays 0.
  - Entry is consumed; pending_mask is unchanged.
- Assert rst during DRAIN with 3 entries buffered:
  - Outputs immediately go to reset values.
  - No rf write occurs after reset deasserts.
